// File: rtl/orion_mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch (I) and load/store (D).
// D has priority; a saturating streak counter hands the port to a waiting I after MAX_D_STREAK D grants.
module orion_mem_arbiter #(
  parameter int ADDRW        = 32,
  parameter int DATAW        = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDRW-1:0]     i_addr,
  input  logic                 i_valid,
  output logic [DATAW-1:0]     i_rdata,
  output logic                 i_ack,
  input  logic [ADDRW-1:0]     d_addr,
  input  logic                 d_valid,
  input  logic [DATAW-1:0]     d_wdata,
  input  logic [DATAW/8-1:0]   d_mask,
  input  logic                 d_we,
  output logic [DATAW-1:0]     d_rdata,
  output logic                 d_ack,
  output logic [ADDRW-1:0]     m_addr,
  output logic                 m_valid,
  output logic [DATAW-1:0]     m_wdata,
  output logic [DATAW/8-1:0]   m_mask,
  output logic                 m_we,
  input  logic [DATAW-1:0]     m_rdata,
  input  logic                 m_ack,
  output logic                 busy
);

  localparam int MASKW = DATAW / 8;
  localparam int SW    = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [SW-1:0]   r_streak;
  logic            w_arb;
  logic            w_cand_i;
  logic            w_cand_d;
  logic            w_streak_full;
  logic            w_pick_i;
  logic            w_pick_d;

  // A port being acked this cycle still shows its old valid, so it is not a candidate.
  assign w_arb         = (r_state == IDLE) | m_ack;
  assign w_cand_i      = i_valid & (r_state != GNT_I);
  assign w_cand_d      = d_valid & (r_state != GNT_D);
  assign w_streak_full = (r_streak == SW'(MAX_D_STREAK));
  assign w_pick_i      = w_arb & w_cand_i & (~w_cand_d | w_streak_full);
  assign w_pick_d      = w_arb & w_cand_d & ~w_pick_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path leaves the output unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    if (w_arb) begin
      if (w_pick_d)      w_next_state = GNT_D;
      else if (w_pick_i) w_next_state = GNT_I;
      else               w_next_state = IDLE;
    end
  end

  always_comb begin
    i_ack   = m_ack & (r_state == GNT_I);
    d_ack   = m_ack & (r_state == GNT_D);
    i_rdata = m_rdata;
    d_rdata = m_rdata;
    busy    = (r_state != IDLE);
  end

  // Memory request registers only load at an arbitration point, so requester changes mid-grant are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_mask  <= '0;
      m_we    <= 1'b0;
    end else if (w_arb) begin
      if (w_pick_d) begin
        m_valid <= 1'b1;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_mask  <= d_mask;
        m_we    <= d_we;
      end else if (w_pick_i) begin
        m_valid <= 1'b1;
        m_addr  <= i_addr;
        m_wdata <= '0;
        m_mask  <= {MASKW{1'b1}};
        m_we    <= 1'b0;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else if (w_pick_d) begin
      if (!i_valid)           r_streak <= '0;
      else if (!w_streak_full) r_streak <= r_streak + SW'(1);
    end else if (w_pick_i) begin
      r_streak <= '0;
    end
  end

endmodule

// File: tb/tb_orion_mem_arbiter.sv
// Directed bench for orion_mem_arbiter: reset, single requests, priority, starvation bound,
// reset abort, request hold, and a randomised I/D traffic run with per-request ack accounting.
module tb_orion_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic [31:0] d_addr;
  logic        d_valid;
  logic [31:0] d_wdata;
  logic [3:0]  d_mask;
  logic        d_we;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [31:0] m_addr;
  logic        m_valid;
  logic [31:0] m_wdata;
  logic [3:0]  m_mask;
  logic        m_we;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  orion_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_addr(d_addr), .d_valid(d_valid), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_we(d_we), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_addr(m_addr), .m_valid(m_valid), .m_wdata(m_wdata), .m_mask(m_mask),
    .m_we(m_we), .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  iss_i, iss_d, ack_i_n, ack_d_n;
  bit  pend_i, pend_d;

  initial begin
    rst = 1'b1; i_addr = '0; i_valid = 1'b0; d_addr = '0; d_valid = 1'b0;
    d_wdata = '0; d_mask = '0; d_we = 1'b0; m_rdata = '0; m_ack = 1'b1;

    // Reset state, and a stale ack straight after reset is dropped
    tick(); tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_we", m_we, 0);
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    rst = 1'b0;
    #1;
    check("stale_i_ack", i_ack, 0);
    check("stale_d_ack", d_ack, 0);
    tick();
    m_ack = 1'b0;

    // 1. Instruction fetch only, ack two cycles after m_valid
    i_valid = 1'b1; i_addr = 32'h100;
    tick();
    check("i_m_valid", m_valid, 1);
    check("i_m_addr", m_addr, 32'h100);
    check("i_m_we", m_we, 0);
    check("i_m_mask", m_mask, 4'hF);
    check("i_busy", busy, 1);
    tick(); tick();
    check("i_no_early_ack", i_ack, 0);
    m_ack = 1'b1; m_rdata = 32'h1122_3344;
    #1;
    check("i_ack", i_ack, 1);
    check("i_d_ack_low", d_ack, 0);
    check("i_rdata", i_rdata, 32'h1122_3344);
    tick();
    m_ack = 1'b0; i_valid = 1'b0;
    check("i_done_m_valid", m_valid, 0);
    check("i_done_busy", busy, 0);

    // 2. Store only
    d_valid = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_mask = 4'b0011; d_we = 1'b1;
    tick();
    check("st_m_addr", m_addr, 32'h2000);
    check("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
    check("st_m_mask", m_mask, 4'b0011);
    check("st_m_we", m_we, 1);
    tick();
    m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
    #1;
    check("st_d_ack", d_ack, 1);
    check("st_i_ack_low", i_ack, 0);
    check("st_d_rdata", d_rdata, 32'h0BAD_F00D);
    tick();
    m_ack = 1'b0; d_valid = 1'b0;
    check("st_done_busy", busy, 0);

    // 3. Both valid in IDLE: D first, then I back-to-back with no bubble
    i_valid = 1'b1; i_addr = 32'h300;
    d_valid = 1'b1; d_addr = 32'h400; d_we = 1'b0; d_mask = 4'hF; d_wdata = 32'h5555_AAAA;
    tick();
    check("both_first_d", m_addr, 32'h400);
    m_ack = 1'b1; m_rdata = 32'hA5A5_A5A5;
    #1;
    check("both_d_ack", d_ack, 1);
    check("both_i_wait", i_ack, 0);
    tick();
    m_ack = 1'b0; d_valid = 1'b0;
    check("b2b_m_valid", m_valid, 1);
    check("b2b_m_addr", m_addr, 32'h300);
    check("b2b_m_wdata", m_wdata, 0);
    check("b2b_m_mask", m_mask, 4'hF);
    m_ack = 1'b1;
    #1;
    check("b2b_i_ack", i_ack, 1);
    tick();
    m_ack = 1'b0; i_valid = 1'b0;
    check("b2b_idle", m_valid, 0);

    // 4. D held, I waiting at each grant: D,D,D,D then I
    d_valid = 1'b1; d_addr = 32'h600; d_we = 1'b0;
    i_addr = 32'h700;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1;
      tick();
      check($sformatf("streak_d%0d", k), m_addr, 32'h600);
      i_valid = 1'b0; m_ack = 1'b1;
      #1;
      check($sformatf("streak_d%0d_ack", k), d_ack, 1);
      tick();
      m_ack = 1'b0;
      check($sformatf("streak_gap%0d", k), m_valid, 0);
    end
    i_valid = 1'b1;
    tick();
    check("streak_i_wins", m_addr, 32'h700);
    d_valid = 1'b0; m_ack = 1'b1;
    #1;
    check("streak_i_ack", i_ack, 1);
    tick();
    m_ack = 1'b0; i_valid = 1'b0;
    i_valid = 1'b1; d_valid = 1'b1;
    tick();
    check("streak_cleared", m_addr, 32'h600);
    i_valid = 1'b0; m_ack = 1'b1;
    tick();
    m_ack = 1'b0; d_valid = 1'b0;

    // 5. Reset while GNT_D waits for m_ack; late ack is ignored
    d_valid = 1'b1; d_addr = 32'h800; d_we = 1'b1;
    tick();
    check("abort_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_m_valid", m_valid, 0);
    check("abort_busy", busy, 0);
    d_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    m_ack = 1'b1;
    #1;
    check("late_d_ack", d_ack, 0);
    check("late_i_ack", i_ack, 0);
    tick();
    m_ack = 1'b0;
    check("late_idle", m_valid, 0);

    // 6a. Requester address change mid-grant does not reach m_addr
    d_valid = 1'b1; d_addr = 32'h500; d_we = 1'b0;
    tick();
    d_addr = 32'h5FC;
    tick();
    check("hold_m_addr", m_addr, 32'h500);
    m_ack = 1'b1;
    #1;
    check("hold_d_ack", d_ack, 1);
    tick();
    m_ack = 1'b0; d_valid = 1'b0;

    // 6b. Random I/D traffic: every request acked exactly once, to its owner
    iss_i = 0; iss_d = 0; ack_i_n = 0; ack_d_n = 0; pend_i = 0; pend_d = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (iss_i == 10 && iss_d == 10 && !pend_i && !pend_d) break;
      if (!pend_i && iss_i < 10 && $urandom_range(0, 2) == 0) begin
        pend_i = 1; i_addr = 32'h1000 + 32'(iss_i) * 4; i_valid = 1'b1; iss_i++;
      end
      if (!pend_d && iss_d < 10 && $urandom_range(0, 2) == 0) begin
        pend_d = 1; d_addr = 32'h9000 + 32'(iss_d) * 4; d_we = 1'($urandom_range(0, 1));
        d_wdata = $urandom; d_mask = 4'hF; d_valid = 1'b1; iss_d++;
      end
      m_ack   = m_valid && ($urandom_range(0, 1) == 1);
      m_rdata = $urandom;
      #1;
      if (m_ack) begin
        if (m_addr[15]) begin
          check("rnd_d_pend", 32'(pend_d), 1);
          check("rnd_d_addr", m_addr, d_addr);
          check("rnd_d_ack", d_ack, 1);
          check("rnd_d_no_i", i_ack, 0);
          pend_d = 0; d_valid = 1'b0; ack_d_n++;
        end else begin
          check("rnd_i_pend", 32'(pend_i), 1);
          check("rnd_i_addr", m_addr, i_addr);
          check("rnd_i_ack", i_ack, 1);
          check("rnd_i_no_d", d_ack, 0);
          pend_i = 0; i_valid = 1'b0; ack_i_n++;
        end
      end
      tick();
    end
    m_ack = 1'b0;
    check("rnd_i_count", 32'(ack_i_n), 10);
    check("rnd_d_count", 32'(ack_d_n), 10);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
